// File: rtl/sva_delay_checker.sv
// sva_delay_checker: multi-attempt checker for "a |-> ##[MIN_DLY:MAX_DLY] b".
// gclk is sampled as data on sys_clk; each rising edge of gclk is one tick.
// Each tick runs a scan of the attempt table, one slot per sys_clk cycle.
// After the scan, a SPAWN cycle may open a new attempt.
module sva_delay_checker #(
    parameter int MAX_THREADS = 4,
    parameter int MIN_DLY     = 1,
    parameter int MAX_DLY     = 3,
    parameter int CNT_W       = 16,
    parameter int DLY_W       = $clog2(MAX_DLY + 1)
) (
    input  logic                               sys_clk,
    input  logic                               sys_rst,
    input  logic                               grst,
    input  logic                               gclk,
    input  logic                               a,
    input  logic                               b,
    output logic                               busy,
    output logic                               succ,
    output logic                               fail,
    output logic                               overflow,
    output logic                               tick_miss,
    output logic [$clog2(MAX_THREADS+1)-1:0]   active_cnt,
    output logic [CNT_W-1:0]                   succ_cnt,
    output logic [CNT_W-1:0]                   fail_cnt,
    output logic [CNT_W-1:0]                   ovf_cnt
);

    localparam int ACT_W = $clog2(MAX_THREADS + 1);
    localparam int IDX_W = (MAX_THREADS > 1) ? $clog2(MAX_THREADS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, SPAWN} state_t;

    state_t                              state, state_nxt;
    logic                                gclk_d0, gclk_d1, tick;
    logic                                a_s, b_s;
    logic [MAX_THREADS-1:0]              vld;
    logic [MAX_THREADS-1:0][DLY_W-1:0]   age;
    logic [IDX_W-1:0]                    idx;

    // per-slot scan decode and spawn helpers
    logic                                scan_last;
    logic                                cur_vld;
    logic [DLY_W:0]                      age_n;
    logic                                hit, expire;
    logic                                free_ok;
    logic [IDX_W-1:0]                    free_idx;
    logic [ACT_W-1:0]                    pop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // grst suppresses ticks so a simultaneous tick and grst is ignored
    assign tick = gclk_d0 & ~gclk_d1 & ~grst;
    assign busy = (state != IDLE);

    // gclk edge detector; grst clears the history
    always_ff @(posedge sys_clk) begin
        if (sys_rst || grst) begin
            gclk_d0 <= 1'b0;
            gclk_d1 <= 1'b0;
        end else begin
            gclk_d0 <= gclk;
            gclk_d1 <= gclk_d0;
        end
    end

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (sys_rst || grst) state <= IDLE;
        else                 state <= state_nxt;
    end

    // FSM next-state: IDLE -> SCAN (one slot per cycle) -> SPAWN -> IDLE
    always_comb begin
        state_nxt = state;
        scan_last = (idx == IDX_W'(MAX_THREADS - 1));
        case (state)
            IDLE:    if (tick) state_nxt = SCAN;
            SCAN:    if (scan_last) state_nxt = SPAWN;
            SPAWN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // decode the slot under the scan pointer; age_n is one bit wider so it never wraps
    always_comb begin
        cur_vld = vld[idx];
        age_n   = {1'b0, age[idx]} + (DLY_W+1)'(1);
        hit     = b_s && (int'(age_n) >= MIN_DLY) && (int'(age_n) <= MAX_DLY);
        expire  = (int'(age_n) >= MAX_DLY);
    end

    // lowest-index free slot (descending loop so the lowest wins)
    always_comb begin
        free_ok  = 1'b0;
        free_idx = '0;
        for (int k = MAX_THREADS - 1; k >= 0; k--) begin
            if (!vld[k]) begin
                free_ok  = 1'b1;
                free_idx = IDX_W'(k);
            end
        end
    end

    // occupancy count; registered below so it trails slot changes by one cycle
    always_comb begin
        pop = '0;
        for (int k = 0; k < MAX_THREADS; k++) pop = pop + ACT_W'(vld[k]);
    end

    // attempt table, sampled inputs, pulses and statistics
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            a_s        <= 1'b0;
            b_s        <= 1'b0;
            vld        <= '0;
            age        <= '0;
            idx        <= '0;
            succ       <= 1'b0;
            fail       <= 1'b0;
            overflow   <= 1'b0;
            tick_miss  <= 1'b0;
            active_cnt <= '0;
            succ_cnt   <= '0;
            fail_cnt   <= '0;
            ovf_cnt    <= '0;
        end else begin
            succ       <= 1'b0;
            fail       <= 1'b0;
            overflow   <= 1'b0;
            active_cnt <= pop;
            // a dropped tick leaves every age one behind; flag it, do not repair it
            if (tick && state != IDLE) tick_miss <= 1'b1;
            if (grst) begin
                vld <= '0;
                age <= '0;
                idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (tick) begin
                            a_s <= a;
                            b_s <= b;
                            idx <= '0;
                        end
                    end
                    SCAN: begin
                        idx <= idx + IDX_W'(1);
                        if (cur_vld) begin
                            if (hit) begin
                                succ      <= 1'b1;
                                vld[idx]  <= 1'b0;
                                age[idx]  <= '0;
                                succ_cnt  <= sat_inc(succ_cnt);
                            end else if (expire) begin
                                fail      <= 1'b1;
                                vld[idx]  <= 1'b0;
                                age[idx]  <= '0;
                                fail_cnt  <= sat_inc(fail_cnt);
                            end else begin
                                age[idx]  <= age_n[DLY_W-1:0];
                            end
                        end
                    end
                    SPAWN: begin
                        if (a_s) begin
                            // zero-delay window: the attempt is satisfied on its own tick
                            if (MIN_DLY == 0 && b_s) begin
                                succ     <= 1'b1;
                                succ_cnt <= sat_inc(succ_cnt);
                            end else if (free_ok) begin
                                vld[free_idx] <= 1'b1;
                                age[free_idx] <= '0;
                            end else begin
                                overflow <= 1'b1;
                                ovf_cnt  <= sat_inc(ovf_cnt);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sva_delay_checker.sv
// Directed bench for sva_delay_checker: a default instance plus a
// MIN_DLY=0, two-slot instance for the zero-delay and overflow cases.
module tb_sva_delay_checker;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic grst = 1'b0;
    logic gclk = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;

    logic        busy0, succ0, fail0, ovf0, miss0;
    logic [2:0]  act0;
    logic [15:0] sc0, fc0, oc0;
    logic        busy1, succ1, fail1, ovf1, miss1;
    logic [1:0]  act1;
    logic [15:0] sc1, fc1, oc1;

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int n_succ0 = 0, n_fail0 = 0, n_ovf0 = 0;
    int n_succ1 = 0, n_fail1 = 0, n_ovf1 = 0;
    int last_sc = 0, prev_sc = 0;

    always #5 sys_clk = ~sys_clk;

    sva_delay_checker dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .grst(grst), .gclk(gclk), .a(a), .b(b),
        .busy(busy0), .succ(succ0), .fail(fail0), .overflow(ovf0), .tick_miss(miss0),
        .active_cnt(act0), .succ_cnt(sc0), .fail_cnt(fc0), .ovf_cnt(oc0)
    );

    sva_delay_checker #(.MAX_THREADS(2), .MIN_DLY(0), .MAX_DLY(3)) dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .grst(grst), .gclk(gclk), .a(a), .b(b),
        .busy(busy1), .succ(succ1), .fail(fail1), .overflow(ovf1), .tick_miss(miss1),
        .active_cnt(act1), .succ_cnt(sc1), .fail_cnt(fc1), .ovf_cnt(oc1)
    );

    // pulse tallies, sampled on the falling edge
    always @(negedge sys_clk) begin
        cyc = cyc + 1;
        if (succ0) begin prev_sc = last_sc; last_sc = cyc; n_succ0 = n_succ0 + 1; end
        if (fail0) n_fail0 = n_fail0 + 1;
        if (ovf0)  n_ovf0  = n_ovf0 + 1;
        if (succ1) n_succ1 = n_succ1 + 1;
        if (fail1) n_fail1 = n_fail1 + 1;
        if (ovf1)  n_ovf1  = n_ovf1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1; grst = 1'b0; gclk = 1'b0; a = 1'b0; b = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    // one gclk period of 20 sys_clk, well above the minimum scan spacing
    task automatic do_tick(input logic av, input logic bv);
        @(negedge sys_clk);
        a = av; b = bv; gclk = 1'b1;
        repeat (10) @(negedge sys_clk);
        gclk = 1'b0;
        repeat (10) @(negedge sys_clk);
    endtask

    initial begin
        int s0, f0, o0, s1, f1, o1;
        bit seen;

        // reset state
        do_reset();
        chk("rst_busy", busy0, 0);
        chk("rst_active", act0, 0);
        chk("rst_succ_cnt", sc0, 0);
        chk("rst_fail_cnt", fc0, 0);
        chk("rst_ovf_cnt", oc0, 0);
        chk("rst_tick_miss", miss0, 0);
        chk("rst_cnt1", {sc1, oc1}, 0);

        // 1: a@0, b only @2 -> pass on tick 2
        do_tick(1, 0);
        chk("t1_active_after_spawn", act0, 1);
        do_tick(0, 0);
        s0 = n_succ0;
        do_tick(0, 1);
        chk("t1_succ_pulses", n_succ0 - s0, 1);
        chk("t1_succ_cnt", sc0, 1);
        chk("t1_active_end", act0, 0);

        // 2: a@0, b never -> fail on tick 3 when age reaches MAX_DLY
        do_reset();
        do_tick(1, 0);
        f0 = n_fail0;
        do_tick(0, 0);
        do_tick(0, 0);
        chk("t2_no_early_fail", n_fail0 - f0, 0);
        chk("t2_active_mid", act0, 1);
        do_tick(0, 0);
        chk("t2_fail_pulses", n_fail0 - f0, 1);
        chk("t2_fail_cnt", fc0, 1);
        chk("t2_active_end", act0, 0);

        // 3: a held for ticks 0..4, b low; at most three live attempts, so no drop
        do_reset();
        o0 = n_ovf0;
        do_tick(1, 0);
        do_tick(1, 0);
        do_tick(1, 0);
        f0 = n_fail0;
        do_tick(1, 0);
        chk("t3_fail_tick3", n_fail0 - f0, 1);
        chk("t3_active_tick3", act0, 3);
        do_tick(1, 0);
        chk("t3_fail_tick4", n_fail0 - f0, 2);
        chk("t3_active_tick4", act0, 3);
        chk("t3_ovf_cnt", oc0, 0);
        chk("t3_ovf_pulses", n_ovf0 - o0, 0);

        // 3b: two-slot instance fills on tick 1 and drops the tick-2 spawn
        do_reset();
        o1 = n_ovf1;
        f1 = n_fail1;
        do_tick(1, 0);
        do_tick(1, 0);
        do_tick(1, 0);
        chk("t3b_ovf_pulses", n_ovf1 - o1, 1);
        chk("t3b_ovf_cnt", oc1, 1);
        chk("t3b_active_full", act1, 2);
        do_tick(1, 0);
        chk("t3b_fail_reuse", n_fail1 - f1, 1);
        chk("t3b_ovf_cnt_hold", oc1, 1);

        // 4: MIN_DLY=0, a and b together -> immediate pass, no slot used
        do_reset();
        s1 = n_succ1;
        do_tick(1, 1);
        chk("t4_succ_pulses", n_succ1 - s1, 1);
        chk("t4_succ_cnt", sc1, 1);
        chk("t4_active", act1, 0);

        // 5: attempts at ticks 0 and 1 both satisfied by b at tick 2
        do_reset();
        do_tick(1, 0);
        do_tick(1, 0);
        s0 = n_succ0;
        do_tick(0, 1);
        chk("t5_succ_pulses", n_succ0 - s0, 2);
        chk("t5_consecutive", last_sc - prev_sc, 1);
        chk("t5_succ_cnt", sc0, 2);
        chk("t5_active", act0, 0);

        // 6: grst with three live attempts, fired during the scan of the expiring tick
        do_reset();
        do_tick(1, 0);
        do_tick(1, 1);
        do_tick(1, 0);
        do_tick(1, 0);
        chk("t6_active_pre", act0, 3);
        chk("t6_succ_cnt_pre", sc0, 1);
        f0 = n_fail0;
        @(negedge sys_clk);
        a = 1'b0; b = 1'b0; gclk = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge sys_clk);
            if (busy0) seen = 1'b1;
        end
        chk("t6_scan_started", seen, 1);
        grst = 1'b1;
        repeat (2) @(negedge sys_clk);
        gclk = 1'b0;
        @(negedge sys_clk);
        grst = 1'b0;
        repeat (10) @(negedge sys_clk);
        chk("t6_no_fail", n_fail0 - f0, 0);
        chk("t6_active_cleared", act0, 0);
        chk("t6_idle", busy0, 0);
        chk("t6_succ_cnt_kept", sc0, 1);
        chk("t6_fail_cnt_kept", fc0, 0);

        // 6b: scan plus detection takes 6 cycles, so a 4-cycle gclk lands mid-scan
        chk("t6b_miss_before", miss0, 0);
        for (int k = 0; k < 4; k++) begin
            gclk = 1'b1;
            repeat (2) @(negedge sys_clk);
            gclk = 1'b0;
            repeat (2) @(negedge sys_clk);
        end
        repeat (20) @(negedge sys_clk);
        chk("t6b_miss_set", miss0, 1);
        grst = 1'b1;
        repeat (2) @(negedge sys_clk);
        grst = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("t6b_miss_kept_grst", miss0, 1);
        do_reset();
        chk("t6b_miss_cleared", miss0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
